// File: rtl/grid_gpu.sv
// grid_gpu: tile-puzzle display engine.
// Maps the scan address into a square tile window, fetches tile pixels through the
// per-tile offset table, blinks the cursor tile and decodes cursor commands into
// cursor moves or single-cycle row/column shift strobes for the offset RAM.
module grid_gpu #(
  parameter int unsigned GRID_BITS  = 4,
  parameter int unsigned COLOR_W    = 3,
  parameter int unsigned COORD_W    = 11,
  parameter int unsigned WIN_X0     = 231,
  parameter int unsigned WIN_Y0     = 36,
  parameter int unsigned WIN_SIZE   = 481,
  parameter int unsigned FLASH_BITS = 25
) (
  input  logic                   i_sysclk,
  input  logic                   i_rst_n,
  input  logic [2:0]             i_cmd,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_scramble,
  input  logic [2*COORD_W-1:0]   i_display_addr,
  output logic [2*COORD_W-1:0]   o_mapper_display_addr,
  input  logic [GRID_BITS-1:0]   i_mapper_pixel_x,
  input  logic [GRID_BITS-1:0]   i_mapper_pixel_y,
  output logic [GRID_BITS-1:0]   o_offset_pos_x,
  output logic [GRID_BITS-1:0]   o_offset_pos_y,
  input  logic [GRID_BITS-1:0]   i_offset_x,
  input  logic [GRID_BITS-1:0]   i_offset_y,
  output logic [2*GRID_BITS-1:0] o_pixel_addr,
  input  logic [COLOR_W-1:0]     i_pixel_data,
  output logic [COLOR_W-1:0]     o_display_data,
  output logic                   o_ram_write,
  output logic [GRID_BITS-1:0]   o_ram_write_pos,
  output logic                   o_ram_write_horizontal,
  output logic                   o_ram_write_increase
);

  localparam logic [COORD_W-1:0]    LP_X_LO   = COORD_W'(WIN_X0);
  localparam logic [COORD_W-1:0]    LP_X_HI   = COORD_W'(WIN_X0 + WIN_SIZE - 1);
  localparam logic [COORD_W-1:0]    LP_Y_LO   = COORD_W'(WIN_Y0);
  localparam logic [COORD_W-1:0]    LP_Y_HI   = COORD_W'(WIN_Y0 + WIN_SIZE - 1);
  localparam logic [GRID_BITS-1:0]  LP_G_ONE  = GRID_BITS'(1);
  localparam logic [FLASH_BITS-1:0] LP_F_ONE  = FLASH_BITS'(1);

  localparam logic [2:0] LP_CMD_UP    = 3'd1;
  localparam logic [2:0] LP_CMD_RIGHT = 3'd2;
  localparam logic [2:0] LP_CMD_LEFT  = 3'd3;
  localparam logic [2:0] LP_CMD_DOWN  = 3'd4;
  localparam logic [2:0] LP_CMD_HOME  = 3'd5;
  localparam logic [2:0] LP_CMD_VIS   = 3'd6;

  typedef enum logic [1:0] {StIdle, StWrite, StRelease} state_e;

  state_e                  r_state;
  logic                    r_cmd_ready;
  logic [GRID_BITS-1:0]    r_cursor_x;
  logic [GRID_BITS-1:0]    r_cursor_y;
  logic                    r_cursor_en;
  logic                    r_ram_write;
  logic [GRID_BITS-1:0]    r_ram_write_pos;
  logic                    r_ram_write_horizontal;
  logic                    r_ram_write_increase;
  logic [FLASH_BITS-1:0]   r_flash_cnt;
  logic                    r_flash_phase;
  logic                    r_in_win;
  logic                    r_is_cur;
  logic [2*GRID_BITS-1:0]  r_pixel_addr;
  logic [COLOR_W-1:0]      r_display_data;

  logic [COORD_W-1:0]      w_x;
  logic [COORD_W-1:0]      w_y;
  logic                    w_in_win;
  logic                    w_is_cur;
  logic [GRID_BITS-1:0]    w_src_x;
  logic [GRID_BITS-1:0]    w_src_y;
  logic                    w_accept;
  logic                    w_is_move;

  // Scan decode, source-tile arithmetic (wraps naturally) and cursor hit test.
  always_comb begin
    w_x       = i_display_addr[2*COORD_W-1:COORD_W];
    w_y       = i_display_addr[COORD_W-1:0];
    w_in_win  = (w_x >= LP_X_LO) && (w_x <= LP_X_HI) && (w_y >= LP_Y_LO) && (w_y <= LP_Y_HI);
    w_src_x   = i_mapper_pixel_x + i_offset_x;
    w_src_y   = i_mapper_pixel_y + i_offset_y;
    w_is_cur  = w_in_win && r_flash_phase && r_cursor_en &&
                (i_mapper_pixel_x == r_cursor_x) && (i_mapper_pixel_y == r_cursor_y);
    w_accept  = i_cmd_valid && (i_cmd != 3'd0);
    w_is_move = (i_cmd == LP_CMD_UP) || (i_cmd == LP_CMD_RIGHT) ||
                (i_cmd == LP_CMD_LEFT) || (i_cmd == LP_CMD_DOWN);
  end

  // Blink timer: phase flips on the edge where the counter wraps back to zero.
  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flash_cnt   <= '0;
      r_flash_phase <= 1'b0;
    end else begin
      r_flash_cnt <= r_flash_cnt + LP_F_ONE;
      if (&r_flash_cnt) r_flash_phase <= ~r_flash_phase;
    end
  end

  // Pixel pipeline stage 1: window flag, cursor flag and ROM address.
  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_win     <= 1'b0;
      r_is_cur     <= 1'b0;
      r_pixel_addr <= '0;
    end else begin
      r_in_win     <= w_in_win;
      r_is_cur     <= w_is_cur;
      r_pixel_addr <= {w_src_y, w_src_x};
    end
  end

  // Pixel pipeline stage 2: blank outside the window, invert the cursor tile.
  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_display_data <= '0;
    end else if (!r_in_win) begin
      r_display_data <= '0;
    end else if (r_is_cur) begin
      r_display_data <= ~i_pixel_data;
    end else begin
      r_display_data <= i_pixel_data;
    end
  end

  // Command FSM: a command is taken once in IDLE; RELEASE waits for cmd_valid to drop.
  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state                <= StIdle;
      r_cmd_ready            <= 1'b1;
      r_cursor_x             <= '0;
      r_cursor_y             <= '0;
      r_cursor_en            <= 1'b1;
      r_ram_write            <= 1'b0;
      r_ram_write_pos        <= '0;
      r_ram_write_horizontal <= 1'b0;
      r_ram_write_increase   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            if (i_scramble && w_is_move) begin
              // Shift fields are latched here and held until the next shift.
              r_state     <= StWrite;
              r_ram_write <= 1'b1;
              case (i_cmd)
                LP_CMD_UP: begin
                  r_ram_write_pos        <= r_cursor_x;
                  r_ram_write_horizontal <= 1'b0;
                  r_ram_write_increase   <= 1'b1;
                end
                LP_CMD_DOWN: begin
                  r_ram_write_pos        <= r_cursor_x;
                  r_ram_write_horizontal <= 1'b0;
                  r_ram_write_increase   <= 1'b0;
                end
                LP_CMD_RIGHT: begin
                  r_ram_write_pos        <= r_cursor_y;
                  r_ram_write_horizontal <= 1'b1;
                  r_ram_write_increase   <= 1'b0;
                end
                default: begin
                  r_ram_write_pos        <= r_cursor_y;
                  r_ram_write_horizontal <= 1'b1;
                  r_ram_write_increase   <= 1'b1;
                end
              endcase
            end else begin
              r_state <= StRelease;
              case (i_cmd)
                LP_CMD_UP:    r_cursor_y  <= r_cursor_y - LP_G_ONE;
                LP_CMD_DOWN:  r_cursor_y  <= r_cursor_y + LP_G_ONE;
                LP_CMD_RIGHT: r_cursor_x  <= r_cursor_x + LP_G_ONE;
                LP_CMD_LEFT:  r_cursor_x  <= r_cursor_x - LP_G_ONE;
                LP_CMD_HOME: begin
                  r_cursor_x <= '0;
                  r_cursor_y <= '0;
                end
                LP_CMD_VIS:   r_cursor_en <= ~r_cursor_en;
                default: ;
              endcase
            end
          end
        end
        StWrite: begin
          r_ram_write <= 1'b0;
          r_state     <= StRelease;
        end
        StRelease: begin
          if (!i_cmd_valid) begin
            r_state     <= StIdle;
            r_cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_cmd_ready <= 1'b1;
          r_ram_write <= 1'b0;
        end
      endcase
    end
  end

  assign o_mapper_display_addr  = i_display_addr;
  assign o_offset_pos_x         = i_mapper_pixel_x;
  assign o_offset_pos_y         = i_mapper_pixel_y;
  assign o_pixel_addr           = r_pixel_addr;
  assign o_display_data         = r_display_data;
  assign o_cmd_ready            = r_cmd_ready;
  assign o_ram_write            = r_ram_write;
  assign o_ram_write_pos        = r_ram_write_pos;
  assign o_ram_write_horizontal = r_ram_write_horizontal;
  assign o_ram_write_increase   = r_ram_write_increase;

endmodule

// File: doc/grid_gpu.md
# grid_gpu

Parametrised tile-puzzle display engine: maps the VGA scan address onto a square GRID_N×GRID_N tile grid inside a fixed window and fetches tile pixels through the per-tile offset table. It inverts the cursor tile on a blink timer, and turns handshaked cursor commands into either cursor moves or single-cycle row/column shift requests to the offset RAM. It sits between the VGA timing generator, the external coordinate mapper, the offset RAM and the pixel ROM.

## Interface
- GRID_BITS, 4: tile index width; GRID_N = 2**GRID_BITS
- COLOR_W, 3: pixel colour width
- COORD_W, 11: display coordinate width
- WIN_X0, 231 / WIN_Y0, 36: inclusive window origin
- WIN_SIZE, 481: window side in display pixels (last pixel = origin + WIN_SIZE − 1)
- FLASH_BITS, 25: blink counter width

- sysclk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd  in  3  1 up, 2 right, 3 left, 4 down, 5 home, 6 toggle cursor visibility
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- scramble  in  1  1: moves become shift requests; 0: moves move cursor
- display_addr  in  2*COORD_W  {x, y} scan position
- mapper_display_addr  out  2*COORD_W  combinational copy of display_addr
- mapper_pixel_x / mapper_pixel_y  in  GRID_BITS  tile coordinates from mapper, same cycle
- offset_pos_x / offset_pos_y  out  GRID_BITS  combinational copy of mapper tile coordinates
- offset_x / offset_y  in  GRID_BITS  offset-RAM read data, same cycle
- pixel_addr  out  2*GRID_BITS  registered {src_y, src_x}
- pixel_data  in  COLOR_W  pixel ROM data, one cycle after pixel_addr
- display_data  out  COLOR_W  registered colour
- ram_write  out  1  one-cycle shift strobe
- ram_write_pos  out  GRID_BITS  row/column index
- ram_write_horizontal  out  1  1 row shift, 0 column shift
- ram_write_increase  out  1  shift direction

## Operation
- Pixel path:
  - in_win = WIN_X0 ≤ x ≤ WIN_X0+WIN_SIZE−1 and the same test on y with WIN_Y0.
  - src_x = mapper_pixel_x + offset_x mod GRID_N; src_y = mapper_pixel_y + offset_y mod GRID_N. No axis swap.
  - is_cur = in_win, flash_phase, cursor_en, and tile == cursor.
  - Stage 1 registers in_win, is_cur and pixel_addr.
  - Stage 2: display_data = 0 if !in_win, ~pixel_data if is_cur, else pixel_data.
- Blink: flash_cnt increments every cycle. flash_phase toggles on the cycle flash_cnt wraps to 0.
- Command FSM:
  - IDLE: cmd_ready = 1. The FSM accepts a command when cmd_valid is high and cmd ≠ 0.
  - Accepting with scramble = 1 and cmd 1–4 goes to WRITE.
  - Every other accepted command executes in the accept cycle and goes to RELEASE.
  - WRITE: ram_write = 1 for exactly one cycle, then RELEASE.
  - RELEASE: waits for cmd_valid = 0, then returns to IDLE. A held command executes once.
- Scramble field values, latched at accept:
  - up: pos = cursor_x, horizontal 0, increase 1
  - down: pos = cursor_x, horizontal 0, increase 0
  - right: pos = cursor_y, horizontal 1, increase 0
  - left: pos = cursor_y, horizontal 1, increase 1
- The fields are held until the next accepted shift.
- Cursor moves wrap:
  - up at y = 0 goes to GRID_N−1; down at y = GRID_N−1 goes to 0.
  - left/right wrap the same way on x.
- cmd 5 sets the cursor to (0,0). cmd 6 inverts cursor_en. Both run regardless of scramble. cmd 7 is accepted with no effect.
- scramble is sampled only at accept; changes in WRITE or RELEASE do not matter.

## Timing
- Reset values:
  - state IDLE, cursor (0,0), cursor_en 1, flash_cnt 0, flash_phase 0
  - pixel_addr 0, display_data 0, pipeline in_win 0, is_cur 0
  - ram_write 0, ram_write_pos 0, ram_write_horizontal 0, ram_write_increase 0
  - cmd_ready 1 as soon as rst_n deasserts
- display_addr to display_data latency: 2 cycles, fully pipelined, one pixel per cycle.
- Command accept cycle C (shift): ram_write is high in C+1 only. A new command can be accepted no earlier than 2 cycles after cmd_valid falls.
- Cursor updates are visible to is_cur from the cycle after accept.
- Reset asserted mid-operation aborts WRITE with no strobe. Outputs go to their reset values immediately (asynchronous).
- First flash_phase toggle occurs 2**FLASH_BITS cycles after reset release.

## Test plan
- Reset, then scan window corners (231,36), (711,516) and outside (230,36), (712,516) -> inside pixels equal the ROM data 2 cycles later; outside pixels are 0.
- scramble 0, cursor (0,0), cmd 1 held for 10 cycles -> cursor (0,15) once. Then cmd 3 -> (15,15). Then cmd 2 -> (0,15).
- Cursor (3,7), scramble 1, cmd 2 -> exactly one ram_write pulse with pos 7, horizontal 1, increase 0. Cursor unchanged.
- FLASH_BITS = 4, cursor (2,2) -> that tile's colour alternates pixel_data and ~pixel_data every 16 cycles. After cmd 6 it is never inverted.
- mapper (5,9), offset (12,3) -> pixel_addr = {4'd12, 4'd1}, checking wrap and no axis swap.
- Assert rst_n low in the WRITE cycle -> no ram_write pulse. After release, state is IDLE and cursor is (0,0).
